// File: rtl/load_store_unit.sv
// RV32I load/store unit: converts byte/half/word accesses into aligned word accesses
// with byte enables. Optional memory-wait timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_fault,
    output logic [1:0]        rsp_cause
);
    // state | meaning
    // IDLE  | ready for a request
    // MEM   | memory request outstanding, waiting for mem_ack
    // RESP  | one-cycle response pulse
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;

    state_e            state_q;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              rsp_valid_q, rsp_fault_q;
    logic [31:0]       rsp_data_q;
    logic [1:0]        rsp_cause_q;

    logic              req_illegal, req_misaligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_rep;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       rsp_data_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]  tmo_cnt_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        if (req_store)
            req_illegal = (req_funct3 > 3'b010);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 > 3'b101);
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    req_be        = 4'b0001 << req_addr[1:0];
                    req_wdata_rep = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata_rep = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load lane selection works on the raw memory word during the ack cycle.
    always_comb begin
        ld_byte = mem_rdata[8*lane_q +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  rsp_data_d = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  rsp_data_d = {{16{ld_half[15]}}, ld_half};
            3'b100:  rsp_data_d = {24'b0, ld_byte};
            3'b101:  rsp_data_d = {16'b0, ld_half};
            default: rsp_data_d = mem_rdata;
        endcase
        if (store_q)
            rsp_data_d = 32'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b0;
            lane_q      <= 2'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0;
            mem_wdata_q <= 32'b0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_data_q  <= 32'b0;
            rsp_cause_q <= 2'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 1'b0;
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        if (req_illegal || req_misaligned) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                            rsp_data_q  <= 32'b0;
                            rsp_cause_q <= req_illegal ? 2'b10 : 2'b01;
                        end else begin
                            state_q     <= MEM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_store;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= req_be;
                            mem_wdata_q <= req_wdata_rep;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_cause_q <= 2'b00;
                        rsp_data_q  <= rsp_data_d;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt_q == '0) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                        rsp_cause_q <= 2'b11;
                        rsp_data_q  <= 32'b0;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q - 1'b1;
                    end
`endif
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_cause = rsp_cause_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multicycle load/store unit between the datapath (ALU result address, rs2 store data, funct3 from decode) and the word-addressed data memory (memory access block).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into aligned word accesses with byte enables.
- Handshakes with a variable-latency memory; returns sign- or zero-extended load data to the result mux.
- Flags misaligned and illegal-funct3 accesses instead of issuing them.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 16, memory wait limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  datapath issues an access.
- req_ready  out  1  unit is idle and accepts a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rs2).
- mem_req  out  1  memory request held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completed the access; rdata valid this cycle for loads.
- mem_rdata  in  32  memory read word.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  qualified by rsp_valid.
- rsp_cause  out  2  qualified by rsp_fault: 01 misaligned, 10 illegal funct3, 11 timeout.

Behaviour:
- Reset (reset=0 at a rising edge) overrides everything, including an in-flight access.
  - Next state is IDLE.
  - All registered outputs are 0: mem_req, mem_we, mem_be, mem_wdata, mem_addr, rsp_valid, rsp_data, rsp_fault, rsp_cause.
  - req_ready is 1.
- States: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch store flag, funct3, address and wdata.
  - Legal and aligned: go to MEM and drive mem_req=1 the next cycle.
  - Otherwise: go to RESP with fault set. No memory request is issued.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal (cause 10).
- Misaligned (cause 01):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Illegal funct3 takes priority over misaligned.
- MEM:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until the cycle mem_ack=1.
  - On that cycle, capture mem_rdata (loads) and go to RESP.
  - mem_req drops the cycle after ack.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_data and rsp_cause hold their values until the next RESP.
- Minimum latency: request accepted at edge N, mem_req from N+1. Ack at edge M gives rsp_valid during the cycle after M. Fault path: rsp_valid during cycle N+1.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata unchanged.
- Loads:
  - mem_we=0 and mem_be=4'b1111.
  - Select byte addr[1:0] or halfword addr[1] from the captured word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Ignored inputs:
  - mem_ack outside MEM.
  - req_valid outside IDLE; the requester must hold it until req_ready.
- Back-to-back: a request presented during RESP is accepted in the following IDLE cycle.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to MEM, incremented each MEM cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, go to RESP with rsp_fault=1, rsp_cause=11, rsp_data=0.
  - A late mem_ack is ignored.
- Undefined: no counter; MEM waits indefinitely; cause 11 is never produced.

Test Plan:
- Reset with reset=0 during MEM with mem_req=1 → next cycle mem_req=0, req_ready=1, rsp_valid=0.
- LB, addr 0x1003, mem_rdata 0x80FF_7F01, ack after 3 cycles → mem_addr 0x1000; rsp_data 0xFFFF_FF80, fault 0. LBU same access → rsp_data 0x0000_0080.
- SH, addr 0x2002, wdata 0x1234_ABCD → mem_we=1, mem_be=4'b1100, mem_wdata 0xABCD_ABCD, mem_addr 0x2000, held until ack.
- LW at 0x3002 → no mem_req; rsp_valid the next cycle, rsp_fault=1, rsp_cause=01. funct3=011 load at 0x3002 → rsp_cause=10.
- Stores and loads issued back-to-back with single-cycle ack → each rsp_valid pulse lasts one cycle; no request dropped or duplicated.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack → rsp_fault=1, rsp_cause=11 after 4 MEM cycles; mem_req=0 afterwards; an ack injected later has no effect.
